// File: rtl/ps2_pkg.sv
// ---------------------------------------------------------------------------
// ps2_pkg
// Shared definitions for the PS/2 scancode controller:
//   - protocol bytes (break/extended prefixes, Enter, keyboard status bytes)
//   - scancodes of the ten player keys (tank: W S A D Q, train: I K J L U)
//   - prefix-sequencer state enum
//   - bit positions inside the 5-bit held vector {fire,right,left,down,up}
//   - decode_key():     scancode -> (valid, player, key index)
//   - key_code():       (player, key index) -> scancode
//   - fallback_code():  highest-priority held key of a player, or 8'h00
// ---------------------------------------------------------------------------
package ps2_pkg;

    localparam logic [7:0] SC_BREAK     = 8'hF0;
    localparam logic [7:0] SC_EXT       = 8'hE0;
    localparam logic [7:0] SC_ENTER     = 8'h5A;
    localparam logic [7:0] SC_BAT_OK    = 8'hAA;
    localparam logic [7:0] SC_ACK       = 8'hFA;
    localparam logic [7:0] SC_RESEND    = 8'hFE;

    localparam logic [7:0] SC_TANK_UP     = 8'h1D;  // W
    localparam logic [7:0] SC_TANK_DOWN   = 8'h1B;  // S
    localparam logic [7:0] SC_TANK_LEFT   = 8'h1C;  // A
    localparam logic [7:0] SC_TANK_RIGHT  = 8'h23;  // D
    localparam logic [7:0] SC_TANK_FIRE   = 8'h15;  // Q
    localparam logic [7:0] SC_TRAIN_UP    = 8'h43;  // I
    localparam logic [7:0] SC_TRAIN_DOWN  = 8'h42;  // K
    localparam logic [7:0] SC_TRAIN_LEFT  = 8'h3B;  // J
    localparam logic [7:0] SC_TRAIN_RIGHT = 8'h4B;  // L
    localparam logic [7:0] SC_TRAIN_FIRE  = 8'h3C;  // U

    localparam logic       PLAYER_TANK  = 1'b0;
    localparam logic       PLAYER_TRAIN = 1'b1;

    // Index into the held vector; lower index = higher fallback priority.
    localparam logic [2:0] KEY_UP    = 3'd0;
    localparam logic [2:0] KEY_DOWN  = 3'd1;
    localparam logic [2:0] KEY_LEFT  = 3'd2;
    localparam logic [2:0] KEY_RIGHT = 3'd3;
    localparam logic [2:0] KEY_FIRE  = 3'd4;
    localparam int         NUM_KEYS  = 5;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_BRK     = 2'd1,
        ST_EXT     = 2'd2,
        ST_EXT_BRK = 2'd3
    } state_t;

    typedef struct packed {
        logic       valid;
        logic       player;
        logic [2:0] idx;
    } key_map_t;

    function automatic key_map_t decode_key(input logic [7:0] code);
        key_map_t m;
        m = '{valid: 1'b1, player: PLAYER_TANK, idx: KEY_UP};
        case (code)
            SC_TANK_UP:     begin m.player = PLAYER_TANK;  m.idx = KEY_UP;    end
            SC_TANK_DOWN:   begin m.player = PLAYER_TANK;  m.idx = KEY_DOWN;  end
            SC_TANK_LEFT:   begin m.player = PLAYER_TANK;  m.idx = KEY_LEFT;  end
            SC_TANK_RIGHT:  begin m.player = PLAYER_TANK;  m.idx = KEY_RIGHT; end
            SC_TANK_FIRE:   begin m.player = PLAYER_TANK;  m.idx = KEY_FIRE;  end
            SC_TRAIN_UP:    begin m.player = PLAYER_TRAIN; m.idx = KEY_UP;    end
            SC_TRAIN_DOWN:  begin m.player = PLAYER_TRAIN; m.idx = KEY_DOWN;  end
            SC_TRAIN_LEFT:  begin m.player = PLAYER_TRAIN; m.idx = KEY_LEFT;  end
            SC_TRAIN_RIGHT: begin m.player = PLAYER_TRAIN; m.idx = KEY_RIGHT; end
            SC_TRAIN_FIRE:  begin m.player = PLAYER_TRAIN; m.idx = KEY_FIRE;  end
            default:        m.valid = 1'b0;
        endcase
        return m;
    endfunction

    function automatic logic [7:0] key_code(input logic player, input logic [2:0] idx);
        logic [7:0] c;
        c = 8'h00;
        case (idx)
            KEY_UP:    c = (player == PLAYER_TANK) ? SC_TANK_UP    : SC_TRAIN_UP;
            KEY_DOWN:  c = (player == PLAYER_TANK) ? SC_TANK_DOWN  : SC_TRAIN_DOWN;
            KEY_LEFT:  c = (player == PLAYER_TANK) ? SC_TANK_LEFT  : SC_TRAIN_LEFT;
            KEY_RIGHT: c = (player == PLAYER_TANK) ? SC_TANK_RIGHT : SC_TRAIN_RIGHT;
            KEY_FIRE:  c = (player == PLAYER_TANK) ? SC_TANK_FIRE  : SC_TRAIN_FIRE;
            default:   c = 8'h00;
        endcase
        return c;
    endfunction

    // Walk from lowest to highest priority so the last hit wins.
    function automatic logic [7:0] fallback_code(input logic player, input logic [4:0] held);
        logic [7:0] c;
        c = 8'h00;
        for (int i = NUM_KEYS - 1; i >= 0; i--) begin
            if (held[i]) c = key_code(player, 3'(i));
        end
        return c;
    endfunction

endpackage

// File: rtl/ps2_player_keys.sv
// ---------------------------------------------------------------------------
// ps2_player_keys
// Per-player key tracker. Keeps the held vector, the "current key" byte with
// priority fallback on release, and the rate-limited fire pulse generator.
// Ports:
//   clk, reset  : clock, synchronous active-high reset
//   i_make      : one-cycle strobe, key i_idx pressed
//   i_break     : one-cycle strobe, key i_idx released
//   i_idx       : key index {0 up,1 down,2 left,3 right,4 fire}
//   o_held      : held vector {fire,right,left,down,up}
//   o_code      : scancode of most recently pressed held key, 8'h00 if none
//   o_fire      : one-cycle fire pulse
// ---------------------------------------------------------------------------
module ps2_player_keys
    import ps2_pkg::*;
#(
    parameter int   FIRE_COOLDOWN = 5_000_000,
    parameter logic PLAYER        = PLAYER_TANK
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       i_make,
    input  logic       i_break,
    input  logic [2:0] i_idx,
    output logic [4:0] o_held,
    output logic [7:0] o_code,
    output logic       o_fire
);

    localparam int CW = (FIRE_COOLDOWN > 2) ? $clog2(FIRE_COOLDOWN) : 1;
    localparam logic [CW-1:0] COOL_LOAD = CW'(FIRE_COOLDOWN - 1);

    logic [4:0]    r_held;
    logic [7:0]    r_code;
    logic          r_fire;
    logic [CW-1:0] r_cool;

    logic [4:0]    w_bit;
    logic [7:0]    w_code;
    logic          w_is_held;
    logic          w_fire_make;
    logic          w_fire_break;
    logic          w_fire_due;

    assign w_bit        = 5'b00001 << i_idx;
    assign w_code       = key_code(PLAYER, i_idx);
    assign w_is_held    = |(r_held & w_bit);
    assign w_fire_make  = i_make  && (i_idx == KEY_FIRE) && !r_held[KEY_FIRE];
    assign w_fire_break = i_break && (i_idx == KEY_FIRE);
    // A fresh press or a still-held key fires when the cooldown is idle; a
    // release landing on the expiry cycle suppresses that pulse.
    assign w_fire_due   = (w_fire_make || (r_held[KEY_FIRE] && !w_fire_break))
                          && (r_cool == '0);

    always_ff @(posedge clk) begin
        if (reset) begin
            r_held <= '0;
            r_code <= 8'h00;
            r_fire <= 1'b0;
            r_cool <= '0;
        end else begin
            // Typematic repeats (make of a held key) leave everything alone.
            if (i_make && !w_is_held) begin
                r_held <= r_held | w_bit;
                r_code <= w_code;
            end else if (i_break && w_is_held) begin
                r_held <= r_held & ~w_bit;
                if (r_code == w_code) begin
                    r_code <= fallback_code(PLAYER, r_held & ~w_bit);
                end
            end

            r_fire <= w_fire_due;
            // Cooldown keeps running after release so tapping cannot beat it.
            if (w_fire_due) begin
                r_cool <= COOL_LOAD;
            end else if (r_cool != '0) begin
                r_cool <= r_cool - 1'b1;
            end
        end
    end

    assign o_held = r_held;
    assign o_code = r_code;
    assign o_fire = r_fire;

endmodule

// File: rtl/ps2_key_ctrl.sv
// ---------------------------------------------------------------------------
// ps2_key_ctrl
// Scancode controller between the PS/2 byte receiver and the game logic.
// Sequences make / break (F0) / extended (E0) bytes, times out stuck prefix
// sequences, and drives two ps2_player_keys trackers (tank, train).
//
// Input handshake: rx_byte is valid only in a cycle with rx_valid=1; every
// such byte is consumed in that cycle (no back-pressure) and its effect
// appears on the registered outputs in the following cycle.
//
// Ports:
//   clk, reset   : 50 MHz clock, synchronous active-high reset
//   rx_byte      : received scancode byte
//   rx_valid     : one-cycle strobe per byte
//   keycodeout   : {train current key, tank current key}, 8'h00 = none
//   tank_held    : tank held vector {fire,right,left,down,up}
//   train_held   : train held vector {fire,right,left,down,up}
//   tank_fire    : tank fire pulse
//   train_fire   : train fire pulse
//   enter_pulse  : pulse on Enter make
//   proto_err    : pulse on F0/E0 after F0, or prefix timeout
//   dbg_state    : current sequencer state (state_t encoding)
// ---------------------------------------------------------------------------
module ps2_key_ctrl
    import ps2_pkg::*;
#(
    parameter int FIRE_COOLDOWN = 5_000_000,
    parameter int TIMEOUT_CYC   = 250_000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [7:0]  rx_byte,
    input  logic        rx_valid,
    output logic [15:0] keycodeout,
    output logic [4:0]  tank_held,
    output logic [4:0]  train_held,
    output logic        tank_fire,
    output logic        train_fire,
    output logic        enter_pulse,
    output logic        proto_err,
    output logic [1:0]  dbg_state
);

    localparam int TW = (TIMEOUT_CYC > 2) ? $clog2(TIMEOUT_CYC) : 1;
    localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_CYC - 1);

    state_t        r_state;
    state_t        w_state_nx;
    logic [TW-1:0] r_tmo;
    logic          r_enter;
    logic          r_err;

    key_map_t      w_map;
    logic          w_make;
    logic          w_break;
    logic          w_err;
    logic          w_expired;
    logic          w_tank_make;
    logic          w_tank_break;
    logic          w_train_make;
    logic          w_train_break;
    logic [7:0]    w_tank_code;
    logic [7:0]    w_train_code;

    assign w_map = decode_key(rx_byte);

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nx;
        end
    end

    always_comb begin
        w_state_nx = r_state;
        w_make     = 1'b0;
        w_break    = 1'b0;
        w_err      = 1'b0;
        // A byte arriving on the expiry cycle takes precedence over timeout.
        w_expired  = (r_state != ST_IDLE) && !rx_valid && (r_tmo == TMO_LAST);
        if (rx_valid) begin
            case (r_state)
                ST_IDLE: begin
                    if (rx_byte == SC_BREAK) begin
                        w_state_nx = ST_BRK;
                    end else if (rx_byte == SC_EXT) begin
                        w_state_nx = ST_EXT;
                    end else if (rx_byte != SC_BAT_OK && rx_byte != SC_ACK &&
                                 rx_byte != SC_RESEND) begin
                        w_make = 1'b1;
                    end
                end
                ST_BRK: begin
                    w_state_nx = ST_IDLE;
                    if (rx_byte == SC_BREAK || rx_byte == SC_EXT) begin
                        w_err = 1'b1;
                    end else begin
                        w_break = 1'b1;
                    end
                end
                ST_EXT: begin
                    w_state_nx = (rx_byte == SC_BREAK) ? ST_EXT_BRK : ST_IDLE;
                end
                default: begin
                    w_state_nx = ST_IDLE;
                end
            endcase
        end else if (w_expired) begin
            w_state_nx = ST_IDLE;
            w_err      = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_tmo   <= '0;
            r_enter <= 1'b0;
            r_err   <= 1'b0;
        end else begin
            // Cleared on every byte, so entry into a prefix state starts at 0.
            if (rx_valid || r_state == ST_IDLE || w_expired) begin
                r_tmo <= '0;
            end else begin
                r_tmo <= r_tmo + 1'b1;
            end
            r_enter <= w_make && (rx_byte == SC_ENTER);
            r_err   <= w_err;
        end
    end

    assign w_tank_make   = w_make  && w_map.valid && (w_map.player == PLAYER_TANK);
    assign w_tank_break  = w_break && w_map.valid && (w_map.player == PLAYER_TANK);
    assign w_train_make  = w_make  && w_map.valid && (w_map.player == PLAYER_TRAIN);
    assign w_train_break = w_break && w_map.valid && (w_map.player == PLAYER_TRAIN);

    ps2_player_keys #(
        .FIRE_COOLDOWN (FIRE_COOLDOWN),
        .PLAYER        (PLAYER_TANK)
    ) u_tank (
        .clk     (clk),
        .reset   (reset),
        .i_make  (w_tank_make),
        .i_break (w_tank_break),
        .i_idx   (w_map.idx),
        .o_held  (tank_held),
        .o_code  (w_tank_code),
        .o_fire  (tank_fire)
    );

    ps2_player_keys #(
        .FIRE_COOLDOWN (FIRE_COOLDOWN),
        .PLAYER        (PLAYER_TRAIN)
    ) u_train (
        .clk     (clk),
        .reset   (reset),
        .i_make  (w_train_make),
        .i_break (w_train_break),
        .i_idx   (w_map.idx),
        .o_held  (train_held),
        .o_code  (w_train_code),
        .o_fire  (train_fire)
    );

    assign keycodeout  = {w_train_code, w_tank_code};
    assign enter_pulse = r_enter;
    assign proto_err   = r_err;
    assign dbg_state   = r_state;

endmodule

// File: doc/ps2_key_ctrl.md
Name: ps2_key_ctrl

Overview:
Scancode controller that sits between the synchronized PS/2 byte receiver and the game logic (tank and train players).
- Sequences the make/break/extended-prefix protocol with a state machine.
- Maintains per-player held-key state and reports the most recently pressed held key per player.
- Generates rate-limited fire pulses and an Enter pulse.
- Recovers from truncated prefix sequences with a timeout.

Parameters:
FIRE_COOLDOWN, 5_000_000, clk cycles between repeated fire pulses while fire key held (100 ms at 50 MHz); must be >= 2
TIMEOUT_CYC, 250_000, max clk cycles allowed in a prefix state before forced return to IDLE (5 ms at 50 MHz); must be >= 2

Ports:
clk  in  1  system clock (50 MHz)
reset  in  1  synchronous, active-high reset
rx_byte  in  8  received scancode byte, valid only when rx_valid=1
rx_valid  in  1  one-cycle strobe, one per received byte
keycodeout  out  16  [7:0]=tank current key code, [15:8]=train current key code, 8'h00 = none held
tank_held  out  5  {fire,right,left,down,up} held bits, tank (Q,D,A,S,W = 15,23,1C,1B,1D)
train_held  out  5  {fire,right,left,down,up} held bits, train (U,L,J,K,I = 3C,4B,3B,42,43)
tank_fire  out  1  one-cycle fire pulse, tank
train_fire  out  1  one-cycle fire pulse, train
enter_pulse  out  1  one-cycle pulse on Enter (5A) make
proto_err  out  1  one-cycle pulse on protocol error or timeout

Behaviour:
- Reset: state=IDLE; keycodeout=16'h0000; held vectors=0; all pulses=0; cooldown and timeout counters=0. Reset mid-sequence discards any pending prefix.
- All outputs are registered. A byte accepted in cycle N is reflected on the outputs in cycle N+1. There is no back-pressure: every rx_valid byte is consumed.
- FSM on rx_valid:
  - IDLE: F0 -> BRK; E0 -> EXT; AA/FA/FE -> ignored; any other byte = make(byte), stay in IDLE.
  - BRK: E0 or F0 -> proto_err, IDLE; any other byte = break(byte), IDLE.
  - EXT: F0 -> EXT_BRK; any other byte -> ignored (extended keys unmapped), IDLE.
  - EXT_BRK: any byte -> ignored, IDLE.
- Timeout:
  - Counter clears on entry to any non-IDLE state and on every rx_valid.
  - Counter reaching TIMEOUT_CYC-1 while in BRK/EXT/EXT_BRK -> IDLE with proto_err.
  - If rx_valid arrives on the expiry cycle, the byte is processed in the current state and no error is raised.
- make(code) for a mapped key:
  - Sets the held bit and sets the player's keycode byte to that code.
  - Typematic repeat (key already held) changes nothing and does not re-trigger fire.
  - make(5A) -> enter_pulse; keycodeout is unchanged.
  - Unmapped codes are ignored.
- break(code) for a mapped key:
  - Clears the held bit.
  - If code equals the player's current keycode byte, that byte falls back to the highest-priority still-held key in order up, down, left, right, fire, or 8'h00 if none is held.
  - Break of a key that is not held is a no-op.
- Fire (per player, independent):
  - On fire make from not-held: if cooldown=0, pulse next cycle and load cooldown=FIRE_COOLDOWN-1.
  - While held: when cooldown reaches 0, pulse and reload.
  - Cooldown counts down even after release.
  - Release in the same cycle cooldown expires: no pulse.
- The tank and train players update independently; one byte affects at most one player.

Decomposition:
- Package ps2_pkg: scancode constants (F0, E0, 5A, AA/FA/FE, the ten player codes), FSM state enum, key index constants for the 5-bit held vector, and a function mapping code -> (player, index, valid).
- Sub-module ps2_player_keys, instantiated twice (tank, train). It holds the held vector, current code byte, priority fallback, and fire cooldown counter. Inputs: make/break strobes plus key index. Outputs: held, code, fire.
- The top level holds the FSM, the timeout counter, Enter and error pulses, and decode.

Test Plan:
- Reset, then rx 1D -> cycle after: keycodeout=16'h001D, tank_held=5'b00001; then rx F0,1D -> keycodeout=16'h0000, tank_held=0.
- rx 1D, 1C, F0 1C -> keycodeout[7:0] goes 1D -> 1C -> 1D (fallback to up); rx 43 meanwhile -> keycodeout=16'h431D, tank bits untouched.
- FIRE_COOLDOWN=10: rx 15 and hold -> tank_fire pulses 1 cycle after accept and every 10 cycles; repeated 15 bytes add no extra pulses; F0 15 stops pulses.
- TIMEOUT_CYC=20: rx F0 then silence -> proto_err at cycle 20, state IDLE; next rx 1D is treated as make -> keycodeout[7:0]=1D.
- rx E0 F0 1D while W held -> ignored, W stays held; rx F0 F0 -> proto_err, no state change to held keys.
- rx 5A -> enter_pulse for exactly 1 cycle, keycodeout unchanged; reset asserted between F0 and 1D -> following 1D is treated as a make.
